flag_window_tx: RTL and testbench
=================================

# flag_window_tx

Flag window transmitter. It is the driving end of the window/flag protocol consumed by the flag monitor. Each accepted request produces one framed transfer:
- a registered flag level is presented first,
- `window` is then held high for a programmed number of cycles with the flag stable,
- a hold cycle and an inter-window gap follow.

An optional corruption input inverts the flag for single window cycles, so the monitor's invalid-window path can be exercised. The block sits upstream of the monitor in the flag link and in its benches.

## Interface
Parameters:
- `LEN_W`, 8: width of the window-length request, in bits.
- `SETUP`, 1: cycles the flag is driven before `window` rises. Legal range 0..15.
- `GAP`, 2: idle cycles after the hold cycle before a new request is accepted. Legal range 0..15.

Ports:
- `clk`  in  1  clock. The block uses this single clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request strobe. Accepted only in a cycle where `ready`=1 and `win_len`≠0.
- `flag_val`  in  1  flag level for the request. Sampled when the request is accepted.
- `win_len`  in  `LEN_W`  window length in cycles. Sampled when the request is accepted.
- `corrupt`  in  1  inverts `flag_out` for the following cycle, if that cycle is a window cycle.
- `ready`  out  1  high in IDLE only.
- `window`  out  1  framing window to the monitor.
- `flag_out`  out  1  flag level to the monitor.
- `done`  out  1  one-cycle pulse in the hold cycle after `window` falls.

## Operation
- All outputs are registered.
- Reset values, taking effect the cycle after a clock edge with `reset`=1:
  - `ready`=1
  - `window`=0
  - `flag_out`=0
  - `done`=0
  - state IDLE; latched flag and length cleared.
- States and transitions:
  - IDLE: `ready`=1, `window`=0, `flag_out` holds its last value. On an accepted `start`: latch `flag_val` and `win_len`, then go to SETUP. If `SETUP`=0, go directly to WINDOW.
  - SETUP: `flag_out`=latched flag, `window`=0. Lasts exactly `SETUP` cycles, then go to WINDOW.
  - WINDOW: `window`=1, `flag_out`=latched flag ^ corruption term. Lasts exactly the latched length, counted with an `LEN_W`-bit down-counter. Then go to HOLD.
  - HOLD: `window`=0, `flag_out`=latched flag, `done`=1. Lasts one cycle. Then go to GAP, or to IDLE if `GAP`=0.
  - GAP: `window`=0, `flag_out` held, `ready`=0. Lasts exactly `GAP` cycles, then go to IDLE.
- Corruption term = `corrupt` registered with (next state == WINDOW). It affects exactly one cycle and never alters the latched flag.
- Request handling:
  - `win_len`=0: the request is ignored. Nothing is latched, `ready` stays 1, and no `done` pulse is produced.
  - `start` while `ready`=0: ignored and not queued.
  - `start` held high continuously: a new request is accepted in the first cycle `ready` returns to 1.
- `flag_val` and `win_len` are don't-care except in the accepting cycle.
- Reset mid-operation (any state): the transfer is aborted. The next cycle shows the reset values, with no `done` pulse and no residual window cycle.
- Maximum length is 2^`LEN_W`−1 cycles. The length counter never wraps.

## Timing
- Request accepted at the edge ending cycle T:
  - SETUP occupies cycles T+1 .. T+`SETUP`.
  - `window` is high for cycles T+`SETUP`+1 .. T+`SETUP`+L.
  - `done` pulses in cycle T+`SETUP`+L+1.
  - `ready` returns to 1 in cycle T+`SETUP`+L+`GAP`+2.
- Busy time is `SETUP`+L+1+`GAP` cycles.
- `flag_out` is stable from the first SETUP cycle through the HOLD cycle, corruption cycles excepted. This guarantees the monitor samples `window`=0 with the flag still valid.
- `corrupt` asserted in cycle c inverts `flag_out` in cycle c+1 only if c+1 is a window cycle. Otherwise it has no effect.

## Test plan
Benches run with defaults (`SETUP`=1, `GAP`=2, `LEN_W`=8) unless noted. Response checks are against `flag_out`, `window`, `done` and `ready`, plus the paired monitor's output where stated.
- Basic transfer, `flag_val`=1, `win_len`=3, accepted at T:
  - `flag_out`=1 from T+1
  - `window`=1 in T+2..T+4
  - `done`=1 in T+5
  - `ready`=0 in T+1..T+7, `ready`=1 in T+8
  - paired monitor output becomes 1.
- Single-cycle window, `flag_val`=0, `win_len`=1: `window` high only in T+2, `done` in T+3, paired monitor output becomes 0.
- Corruption, `win_len`=4, `flag_val`=1, `corrupt` pulsed in T+2:
  - `flag_out`=0 in T+3 only, 1 in T+4 and T+5
  - paired monitor output unchanged (invalid window).
- Back-to-back requests with `start` held high, `win_len`=3:
  - second request accepted at T+8, second window in T+10..T+12
  - exactly 5 low cycles between windows.
- Boundaries:
  - `win_len`=0: no state change, no `done`.
  - `win_len`=255: exactly 255 window cycles.
  - `SETUP`=0, `GAP`=0 build: `window` in T+1..T+L, `ready`=1 at T+L+2.
- Reset asserted in the 2nd window cycle of a `win_len`=5 transfer: the next cycle shows `window`=0, `flag_out`=0, `ready`=1, and no `done` pulse ever follows.

Source files
------------

// File: rtl/flag_window_tx.sv
// flag_window_tx: driving end of the window/flag link. Each accepted request
// presents a registered flag, holds `window` high for the requested number of
// cycles with the flag stable, then issues a one-cycle hold (done) and a gap.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous, active-high reset
//   start     in   request strobe (accepted when ready=1 and win_len!=0)
//   flag_val  in   flag level, sampled on acceptance
//   win_len   in   window length in cycles, sampled on acceptance
//   corrupt   in   invert flag_out next cycle if that cycle is a window cycle
//   ready     out  high in IDLE
//   window    out  framing window
//   flag_out  out  flag level
//   done      out  one-cycle pulse in the hold cycle
module flag_window_tx #(
    parameter int LEN_W = 8,
    parameter int SETUP = 1,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flag_val,
    input  logic [LEN_W-1:0] win_len,
    input  logic             corrupt,
    output logic             ready,
    output logic             window,
    output logic             flag_out,
    output logic             done
);

    localparam int unsigned PH_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_WINDOW = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    state_t           state_q,    state_d;
    logic [LEN_W-1:0] win_cnt_q,  win_cnt_d;
    logic [PH_W-1:0]  ph_cnt_q,   ph_cnt_d;
    logic             flag_lat_q, flag_lat_d;
    logic             ready_d, window_d, flag_out_d, done_d;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            win_cnt_q  <= '0;
            ph_cnt_q   <= '0;
            flag_lat_q <= 1'b0;
            ready      <= 1'b1;
            window     <= 1'b0;
            flag_out   <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            flag_lat_q <= flag_lat_d;
            ready      <= ready_d;
            window     <= window_d;
            flag_out   <= flag_out_d;
            done       <= done_d;
        end
    end

    // Next state, counters, and next-cycle output values
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        ph_cnt_d   = ph_cnt_q;
        flag_lat_d = flag_lat_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (win_len != '0)) begin
                    flag_lat_d = flag_val;
                    // Window counter doubles as the latched length until WINDOW
                    win_cnt_d  = win_len;
                    if (SETUP == 0) begin
                        state_d = ST_WINDOW;
                    end else begin
                        state_d  = ST_SETUP;
                        ph_cnt_d = PH_W'(SETUP - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (ph_cnt_q == '0) begin
                    state_d = ST_WINDOW;
                end else begin
                    ph_cnt_d = ph_cnt_q - PH_W'(1);
                end
            end
            ST_WINDOW: begin
                // Counter holds remaining cycles including the current one; stops at 0
                win_cnt_d = win_cnt_q - LEN_W'(1);
                if (win_cnt_q == LEN_W'(1)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (GAP == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_GAP;
                    ph_cnt_d = PH_W'(GAP - 1);
                end
            end
            ST_GAP: begin
                if (ph_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    ph_cnt_d = ph_cnt_q - PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d    = (state_d == ST_IDLE);
        window_d   = (state_d == ST_WINDOW);
        done_d     = (state_d == ST_HOLD);
        flag_out_d = flag_out;
        case (state_d)
            ST_SETUP:  flag_out_d = flag_lat_d;
            // Corruption only touches the output register, never the latched flag
            ST_WINDOW: flag_out_d = flag_lat_d ^ corrupt;
            ST_HOLD:   flag_out_d = flag_lat_d;
            default:   flag_out_d = flag_out;
        endcase
    end

endmodule

// File: tb/tb_flag_window_tx.sv
module tb_flag_window_tx;

    localparam int S_A = 1;
    localparam int G_A = 2;
    localparam int S_B = 0;
    localparam int G_B = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_a, flag_val_a, corrupt_a;
    logic [7:0] win_len_a;
    logic       ready_a, window_a, flag_out_a, done_a;
    logic       start_b, flag_val_b, corrupt_b;
    logic [7:0] win_len_b;
    logic       ready_b, window_b, flag_out_b, done_b;

    flag_window_tx #(.LEN_W(8), .SETUP(S_A), .GAP(G_A)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .flag_val(flag_val_a),
        .win_len(win_len_a), .corrupt(corrupt_a), .ready(ready_a),
        .window(window_a), .flag_out(flag_out_a), .done(done_a)
    );

    flag_window_tx #(.LEN_W(8), .SETUP(S_B), .GAP(G_B)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .flag_val(flag_val_b),
        .win_len(win_len_b), .corrupt(corrupt_b), .ready(ready_b),
        .window(window_b), .flag_out(flag_out_b), .done(done_b)
    );

    int checks   = 0;
    int failures = 0;

    // Expected {window, flag_out, done, ready} per cycle
    logic [3:0] sb[$];
    logic       last_flag;

    typedef struct {
        logic       f;
        logic [7:0] len;
        int         co;       // cycle offset from acceptance where corrupt is pulsed, -1 none
        logic       keep;     // hold start high through the transfer
        int         exp_win;  // expected number of window-high cycles
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] outs(input int which);
        if (which == 0) return {window_a, flag_out_a, done_a, ready_a};
        return {window_b, flag_out_b, done_b, ready_b};
    endfunction

    task automatic drive(input int which, input logic st, input logic f,
                         input logic [7:0] l, input logic c);
        if (which == 0) begin
            start_a = st; flag_val_a = f; win_len_a = l; corrupt_a = c;
        end else begin
            start_b = st; flag_val_b = f; win_len_b = l; corrupt_b = c;
        end
    endtask

    // Called at a sample point of a cycle T with ready=1; returns at the cycle ready is back
    task automatic run_xfer(input int which, input int id, input logic f, input logic [7:0] l,
                            input int co, input logic keep, input int exp_win);
        int s, g, busy, wins, ln;
        logic w;
        logic [3:0] e, got;
        s    = (which == 0) ? S_A : S_B;
        g    = (which == 0) ? G_A : G_B;
        ln   = int'(l);
        busy = s + ln + 1 + g;
        for (int j = 1; j <= busy + 1; j++) begin
            w = (j >= s + 1) && (j <= s + ln);
            e = {w, f ^ (w && (co == j - 1)), (j == s + ln + 1), (j >= busy + 1)};
            sb.push_back(e);
        end
        drive(which, 1'b1, f, l, co == 0);
        wins = 0;
        for (int j = 1; j <= busy + 1; j++) begin
            @(posedge clk); #1;
            got = outs(which);
            if (got[3]) wins++;
            e = sb.pop_front();
            check($sformatf("xfer%0d_d%0d_c%0d", id, which, j), 32'(got), 32'(e));
            drive(which, keep, 1'($urandom), 8'($urandom), co == j);
        end
        check($sformatf("xfer%0d_wincount", id), 32'(wins), 32'(exp_win));
        last_flag = f;
    endtask

    initial begin
        vecs[0] = '{f: 1'b1, len: 8'd3,   co: -1, keep: 1'b0, exp_win: 3};
        vecs[1] = '{f: 1'b0, len: 8'd1,   co: -1, keep: 1'b0, exp_win: 1};
        vecs[2] = '{f: 1'b1, len: 8'd4,   co: 2,  keep: 1'b0, exp_win: 4};
        vecs[3] = '{f: 1'b1, len: 8'd3,   co: -1, keep: 1'b1, exp_win: 3};
        vecs[4] = '{f: 1'b1, len: 8'd3,   co: -1, keep: 1'b0, exp_win: 3};
        vecs[5] = '{f: 1'b0, len: 8'd2,   co: 0,  keep: 1'b0, exp_win: 2};
        vecs[6] = '{f: 1'b1, len: 8'd2,   co: 3,  keep: 1'b0, exp_win: 2};
        vecs[7] = '{f: 1'b1, len: 8'd255, co: -1, keep: 1'b0, exp_win: 255};
        vecs[8] = '{f: 1'b0, len: 8'd6,   co: 4,  keep: 1'b0, exp_win: 6};

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 8'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 8'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_a", 32'(outs(0)), 32'h1);
        check("reset_b", 32'(outs(1)), 32'h1);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_xfer(0, i, vecs[i].f, vecs[i].len, vecs[i].co, vecs[i].keep, vecs[i].exp_win);
        end
        drive(0, 1'b0, 1'b0, 8'd0, 1'b0);

        // Zero-length requests are ignored
        drive(0, 1'b1, ~last_flag, 8'd0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(posedge clk); #1;
            check($sformatf("zero_len_c%0d", j), 32'(outs(0)), 32'({1'b0, last_flag, 1'b0, 1'b1}));
        end
        drive(0, 1'b0, 1'b0, 8'd0, 1'b0);

        // No setup / no gap instance
        run_xfer(1, 20, 1'b1, 8'd3, -1, 1'b0, 3);
        run_xfer(1, 21, 1'b0, 8'd1, -1, 1'b0, 1);
        run_xfer(1, 22, 1'b1, 8'd4, 1,  1'b0, 4);
        run_xfer(1, 23, 1'b0, 8'd2, 0,  1'b0, 2);
        drive(1, 1'b0, 1'b0, 8'd0, 1'b0);

        // Reset in the second window cycle of a length-5 transfer
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 8'd5, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 8'd0, 1'b0);
        check("rst_seq_setup", 32'(outs(0)), 32'b0100);
        @(posedge clk); #1;
        check("rst_seq_win1", 32'(outs(0)), 32'b1100);
        @(posedge clk); #1;
        check("rst_seq_win2", 32'(outs(0)), 32'b1100);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_seq_after", 32'(outs(0)), 32'b0001);
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            check($sformatf("rst_seq_idle_c%0d", j), 32'(outs(0)), 32'b0001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
